// File: rtl/l1i_refill.sv
// ----------------------------------------------------------------------------
// l1i_refill
//
// Line-refill engine between the L1 instruction cache and a 32-bit memory bus.
// A cached request fetches the aligned 32-byte line as eight pipelined word
// reads and returns it as one 256-bit beat. An MMIO request performs a single
// uncached word read and returns it in bits [31:0] with the upper bits zero.
// A request that is dropped or redirected mid-transfer still drains every read
// the bus has accepted, but raises no done.
//
// Parameters
//   MMIO_MASK / MMIO_MATCH : address is MMIO when (addr & MASK) == MATCH
//   MAX_OUTSTANDING        : bus reads accepted but not yet answered (1..8)
//
// Ports
//   sys_clk            in   clock, all logic on posedge
//   rst                in   synchronous active-high reset
//   l1_mmu_req_read    in   refill request (level) from the icache
//   l1_mmu_req_addr    in   request address
//   mmu_l1_done        out  one-cycle pulse, mmu_l1_read_data valid
//   mmu_l1_read_data   out  line data, word i at [32i+31:32i]
//   mem_req            out  bus read request valid
//   mem_addr           out  word address of the bus read
//   mem_gnt            in   bus accepted mem_req this cycle
//   mem_rvalid         in   in-order read response valid
//   mem_rdata          in   read response data
//   busy               out  engine is not idle
// ----------------------------------------------------------------------------
module l1i_refill #(
    parameter logic [31:0] MMIO_MASK       = 32'hFFFF_0000,
    parameter logic [31:0] MMIO_MATCH      = 32'hFFFF_0000,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         l1_mmu_req_read,
    input  logic [31:0]  l1_mmu_req_addr,
    output logic         mmu_l1_done,
    output logic [255:0] mmu_l1_read_data,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_MMIO,
        S_DONE,
        S_HOLD
    } state_t;

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t         state_q;
    state_t         state_d;
    logic [31:2]    lat_addr_q;
    logic           lat_mmio_q;
    logic [3:0]     issue_cnt_q;
    logic [3:0]     resp_cnt_q;
    logic [3:0]     outst_q;
    logic [255:0]   line_q;
    logic           done_q;

    logic           req_is_mmio;
    logic           rsp_ok;
    logic           issue_fire;
    logic           line_complete;
    logic           req_matches;

    assign req_is_mmio = (l1_mmu_req_addr & MMIO_MASK) == MMIO_MATCH;

    // A response with nothing outstanding is a bus protocol error; it is
    // dropped so it can neither corrupt the buffer nor underflow outst.
    assign rsp_ok     = mem_rvalid && (outst_q != 4'd0);
    assign issue_fire = mem_req && mem_gnt;

    // High in the cycle whose closing edge captures the final response.
    assign line_complete = rsp_ok &&
                           ((state_q == S_MMIO) ||
                            (state_q == S_FILL && resp_cnt_q == 4'd7));

    // The icache still wants this data if it holds a request for the same
    // line (or the same word for MMIO). Anything else means it was abandoned.
    assign req_matches = l1_mmu_req_read &&
                         (lat_mmio_q ? (l1_mmu_req_addr[31:2] == lat_addr_q[31:2])
                                     : (l1_mmu_req_addr[31:5] == lat_addr_q[31:5]));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and bus request
    // ------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (l1_mmu_req_read) begin
                    state_d = req_is_mmio ? S_MMIO : S_FILL;
                end
            end
            S_FILL: begin
                mem_req  = (issue_cnt_q < 4'd8) && (outst_q < MAX_OUT);
                mem_addr = {lat_addr_q[31:5], issue_cnt_q[2:0], 2'b00};
                if (line_complete) begin
                    state_d = S_DONE;
                end
            end
            S_MMIO: begin
                mem_req  = (issue_cnt_q == 4'd0);
                mem_addr = {lat_addr_q[31:2], 2'b00};
                if (line_complete) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_HOLD;
            // The icache's registered request can lag done by a cycle, so the
            // request is not looked at again until IDLE.
            S_HOLD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------------
    // Counters, address latch, line buffer, done pulse
    // ------------------------------------------------------------------------
    // NOTE: the line buffer is reset along with the control state so the
    // returned data is zero after reset rather than a stale or X line.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            lat_addr_q  <= '0;
            lat_mmio_q  <= 1'b0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            outst_q     <= '0;
            line_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            // Registered done: decided on the edge that lands the last word,
            // so it is high for exactly the DONE cycle.
            done_q <= line_complete && req_matches;

            case (state_q)
                S_IDLE: begin
                    issue_cnt_q <= '0;
                    resp_cnt_q  <= '0;
                    outst_q     <= '0;
                    if (l1_mmu_req_read) begin
                        lat_addr_q <= l1_mmu_req_addr[31:2];
                        lat_mmio_q <= req_is_mmio;
                    end
                end
                S_FILL, S_MMIO: begin
                    if (issue_fire) begin
                        issue_cnt_q <= issue_cnt_q + 4'd1;
                    end
                    if (issue_fire && !rsp_ok) begin
                        outst_q <= outst_q + 4'd1;
                    end else if (!issue_fire && rsp_ok) begin
                        outst_q <= outst_q - 4'd1;
                    end
                    if (rsp_ok) begin
                        resp_cnt_q <= resp_cnt_q + 4'd1;
                        if (state_q == S_MMIO) begin
                            line_q <= {224'b0, mem_rdata};
                        end else begin
                            line_q[{resp_cnt_q[2:0], 5'b0_0000} +: 32] <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mmu_l1_done      = done_q;
    assign mmu_l1_read_data = line_q;

endmodule

// File: tb/tb_l1i_refill.sv
// ----------------------------------------------------------------------------
// tb_l1i_refill
//
// Self-checking bench for l1i_refill. A behavioural bus keeps a queue of
// accepted reads and answers them in order after a programmable delay; the
// memory contents are a simple function of the address. Expected lines and
// bus address sequences are computed from the address alone.
// ----------------------------------------------------------------------------
module tb_l1i_refill;

    localparam int MAX_OUT = 2;

    logic         sys_clk = 1'b0;
    logic         rst;
    logic         l1_mmu_req_read;
    logic [31:0]  l1_mmu_req_addr;
    logic         mmu_l1_done;
    logic [255:0] mmu_l1_read_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt    = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata  = '0;
    logic         busy;

    always #5 sys_clk = ~sys_clk;

    l1i_refill #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .l1_mmu_req_read  (l1_mmu_req_read),
        .l1_mmu_req_addr  (l1_mmu_req_addr),
        .mmu_l1_done      (mmu_l1_done),
        .mmu_l1_read_data (mmu_l1_read_data),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .busy             (busy)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend_q[$];
    logic [31:0]  grant_q[$];
    int           grant_cyc_q[$];
    int           rsp_cyc_q[$];
    int           cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    logic [255:0] done_data = '0;
    int           gnt_mode = 0;     // 0 always, 1 alternate cycles, 2 random
    int           fixed_delay = 1;
    bit           rand_delay = 1'b0;
    int           max_pend = 0;
    int           live_outst = 0;
    logic [31:0]  xor_key = '0;
    int           n_pass = 0;
    int           n_total = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'hFFFF_0004) ? 32'hDEAD_BEEF : (a ^ xor_key);
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return (a & 32'hFFFF_0000) == 32'hFFFF_0000;
    endfunction

    // Reference: the line (or word) the icache should receive for an address.
    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        l = '0;
        if (is_mmio(a)) begin
            l[31:0] = mem_fn({a[31:2], 2'b00});
        end else begin
            for (int i = 0; i < 8; i++) begin
                l[32*i +: 32] = mem_fn({a[31:5], 5'b0} + 32'(4 * i));
            end
        end
        return l;
    endfunction

    // Behavioural bus: respond from the head of the queue, then accept.
    always @(negedge sys_clk) begin
        int d;
        if (rst) begin
            pend_q.delete();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_fn(pend_q[0].addr);
                pend_q.delete(0);
                rsp_cyc_q.push_back(cyc);
            end
            case (gnt_mode)
                1:       mem_gnt = ((cyc % 2) == 0);
                2:       mem_gnt = 1'($urandom_range(0, 1));
                default: mem_gnt = 1'b1;
            endcase
            if (mem_req && mem_gnt) begin
                d = rand_delay ? int'($urandom_range(1, 4)) : fixed_delay;
                pend_q.push_back('{addr: mem_addr, due: cyc + d});
                grant_q.push_back(mem_addr);
                grant_cyc_q.push_back(cyc);
                if (pend_q.size() > max_pend) max_pend = pend_q.size();
            end
        end
    end

    always @(negedge sys_clk) begin
        if (mmu_l1_done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_data = mmu_l1_read_data;
        end
    end

    // A response may only answer a read the bus has accepted.
    always @(posedge sys_clk) begin
        if (rst) begin
            live_outst <= 0;
        end else begin
            assert (!(mem_rvalid && live_outst == 0))
                else $error("rvalid with no outstanding read");
            live_outst <= live_outst + int'(mem_req && mem_gnt) - int'(mem_rvalid);
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input int base, input logic [31:0] addr);
        logic [255:0] act;
        logic [255:0] exp;
        int n;
        act = '0;
        exp = '0;
        n = is_mmio(addr) ? 1 : 8;
        for (int i = 0; i < n; i++) begin
            exp[32*i +: 32] = is_mmio(addr) ? {addr[31:2], 2'b00}
                                            : {addr[31:5], 5'b0} + 32'(4 * i);
            if (base + i < grant_q.size()) act[32*i +: 32] = grant_q[base + i];
        end
        check(name, act, exp);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100; t++) begin
            @(posedge sys_clk); #1;
            if (!busy) break;
        end
        check("idle_before_req", 256'(busy), 256'(0));
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk); #1;
        end
    endtask

    // Issue one request and hold it until done (plus one cycle if lag).
    // lat/frel/lrel are cycle numbers counted from the request-sampling edge.
    task automatic run_req(input logic [31:0] addr, input bit lag,
                           output int lat, output int gbase,
                           output int frel, output int lrel);
        int d0;
        int e0;
        bit got;
        wait_idle();
        d0    = done_cnt;
        gbase = grant_q.size();
        l1_mmu_req_read = 1'b1;
        l1_mmu_req_addr = addr;
        e0  = cyc + 1;
        got = 1'b0;
        for (int t = 0; t < 400 && !got; t++) begin
            @(posedge sys_clk); #1;
            got = (done_cnt != d0);
        end
        check("done_seen", 256'(got), 256'(1));
        lat  = got ? done_cyc - e0 + 1 : -1;
        frel = (grant_q.size() > gbase) ? grant_cyc_q[gbase] - e0 + 1 : -1;
        lrel = (grant_q.size() > gbase) ? grant_cyc_q[grant_q.size() - 1] - e0 + 1 : -1;
        if (lag) begin
            @(posedge sys_clk); #1;
        end
        l1_mmu_req_read = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed table
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          nreads;
        int          lat;
        logic [31:0] word0;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int lat, gb, frel, lrel, d0, rb;
        logic [31:0] a;

        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int lat, gb, frel, lrel, d0, rb, n;
        logic [31:0] a;

        vecs[0] = '{addr: 32'h0000_1234, nreads: 8, lat: 10, word0: 32'h0000_1220};
        vecs[1] = '{addr: 32'hFFFF_0004, nreads: 1, lat: 3,  word0: 32'hDEAD_BEEF};
        vecs[2] = '{addr: 32'hFFFE_FFFC, nreads: 8, lat: 10, word0: 32'hFFFE_FFE0};
        vecs[3] = '{addr: 32'hFFFF_FFFF, nreads: 1, lat: 3,  word0: 32'hFFFF_FFFC};
        vecs[4] = '{addr: 32'h0000_001F, nreads: 8, lat: 10, word0: 32'h0000_0000};
        vecs[5] = '{addr: 32'h8000_0040, nreads: 8, lat: 10, word0: 32'h8000_0040};

        // ---- reset state ----
        rst = 1'b1;
        l1_mmu_req_read = 1'b0;
        l1_mmu_req_addr = '0;
        wait_cycles(3);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_mem_req", 256'(mem_req), 256'(0));
        check("rst_mem_addr", 256'(mem_addr), 256'(0));
        check("rst_done", 256'(mmu_l1_done), 256'(0));
        check("rst_read_data", mmu_l1_read_data, 256'(0));
        rst = 1'b0;

        // ---- zero-wait table ----
        gnt_mode = 0; fixed_delay = 1; rand_delay = 1'b0;
        foreach (vecs[k]) begin
            run_req(vecs[k].addr, 1'b0, lat, gb, frel, lrel);
            check("latency", 256'(lat), 256'(vecs[k].lat));
            check("n_reads", 256'(grant_q.size() - gb), 256'(vecs[k].nreads));
            check("first_req_cycle", 256'(frel), 256'(1));
            check("last_req_cycle", 256'(lrel), 256'(vecs[k].nreads));
            check_seq("addr_seq", gb, vecs[k].addr);
            check("word0", 256'(done_data[31:0]), 256'(vecs[k].word0));
            check("line_data", done_data, ref_line(vecs[k].addr));
            wait_cycles(2);
            check("data_stable", mmu_l1_read_data, ref_line(vecs[k].addr));
        end

        // ---- lagging request: no second fill ----
        d0 = done_cnt;
        run_req(32'h0000_5008, 1'b1, lat, gb, frel, lrel);
        wait_cycles(12);
        check("lag_n_reads", 256'(grant_q.size() - gb), 256'(8));
        check("lag_done_cnt", 256'(done_cnt - d0), 256'(1));

        // ---- backpressure: alternate grant, 3-cycle response ----
        gnt_mode = 1; fixed_delay = 3; max_pend = 0;
        d0 = done_cnt;
        run_req(32'h0000_6660, 1'b0, lat, gb, frel, lrel);
        wait_cycles(6);
        check("bp_done_cnt", 256'(done_cnt - d0), 256'(1));
        check_seq("bp_addr_seq", gb, 32'h0000_6660);
        check("bp_line", done_data, ref_line(32'h0000_6660));
        check("bp_max_outst", 256'(max_pend <= MAX_OUT), 256'(1));

        // ---- long response latency saturates the outstanding limit ----
        gnt_mode = 0; fixed_delay = 6; max_pend = 0;
        run_req(32'h0000_7700, 1'b0, lat, gb, frel, lrel);
        check("lim_line", done_data, ref_line(32'h0000_7700));
        check("lim_max_outst", 256'(max_pend), 256'(MAX_OUT));

        // ---- abandoned request redirected to another line ----
        fixed_delay = 1;
        wait_idle();
        d0 = done_cnt; gb = grant_q.size(); rb = rsp_cyc_q.size();
        l1_mmu_req_read = 1'b1;
        l1_mmu_req_addr = 32'h0000_1000;
        for (int t = 0; t < 50 && grant_q.size() - gb < 3; t++) wait_cycles(1);
        l1_mmu_req_addr = 32'h0000_2008;
        for (int t = 0; t < 400 && done_cnt == d0; t++) wait_cycles(1);
        l1_mmu_req_read = 1'b0;
        wait_cycles(8);
        check("ab_done_cnt", 256'(done_cnt - d0), 256'(1));
        check("ab_n_reads", 256'(grant_q.size() - gb), 256'(16));
        check_seq("ab_old_seq", gb, 32'h0000_1000);
        check_seq("ab_new_seq", gb + 8, 32'h0000_2008);
        check("ab_line", done_data, ref_line(32'h0000_2008));
        if (grant_q.size() - gb >= 9 && rsp_cyc_q.size() - rb >= 8) begin
            check("ab_restart_gap", 256'(grant_cyc_q[gb + 8] - rsp_cyc_q[rb + 7]), 256'(4));
        end else begin
            check("ab_restart_seen", 256'(0), 256'(1));
        end

        // ---- reset mid-fill ----
        fixed_delay = 3;
        wait_idle();
        rb = rsp_cyc_q.size();
        l1_mmu_req_read = 1'b1;
        l1_mmu_req_addr = 32'h0000_3000;
        for (int t = 0; t < 100 && rsp_cyc_q.size() - rb < 3; t++) wait_cycles(1);
        rst = 1'b1;
        l1_mmu_req_read = 1'b0;
        wait_cycles(1);
        rst = 1'b0;
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_mem_req", 256'(mem_req), 256'(0));
        check("mid_rst_read_data", mmu_l1_read_data, 256'(0));
        check("mid_rst_done", 256'(mmu_l1_done), 256'(0));
        fixed_delay = 1;
        run_req(32'h0000_4000, 1'b0, lat, gb, frel, lrel);
        check("post_rst_latency", 256'(lat), 256'(10));
        check_seq("post_rst_seq", gb, 32'h0000_4000);
        check("post_rst_line", done_data, ref_line(32'h0000_4000));

        // ---- randomized traffic against the reference ----
        gnt_mode = 2; rand_delay = 1'b1; max_pend = 0;
        xor_key = $urandom;
        for (int it = 0; it < 24; it++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31:16] = 16'hFFFF;
            n = is_mmio(a) ? 1 : 8;
            d0 = done_cnt;
            run_req(a, 1'($urandom_range(0, 1)), lat, gb, frel, lrel);
            check("rnd_line", done_data, ref_line(a));
            check_seq("rnd_seq", gb, a);
            check("rnd_n_reads", 256'(grant_q.size() - gb), 256'(n));
        end
        wait_cycles(4);
        check("rnd_max_outst", 256'(max_pend <= MAX_OUT), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
